// File: rtl/bcd_encoder_serial.sv
// Serial binary-to-BCD converter using one double-dabble step per clock.
// Optional overflow detection is enabled by LIBSV_BCD_ENCODER_SERIAL_OVERFLOW_EN.
module bcd_encoder_serial #(
  parameter  int N = 3,
  localparam int W = 3 * N + (N + 2) / 3
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [W-1:0]   i_bin,
  input  logic           i_valid,
  output logic           o_ready,
  output logic [4*N-1:0] o_bcd,
  output logic           o_overflow,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [1:0]     o_dbg_state
);

  // Handshake: a value transfers on any rising edge where valid and ready are
  // both high; i_valid matters only in IDLE and i_ready only in DONE.

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    bin_q, bin_d;
  logic [4*N-1:0]  bcd_q, bcd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4*N-1:0]  bcd_adj;
  logic [4*N+W-1:0] shifted;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  // Double-dabble step: digits >= 5 get +3 so the following doubling carries
  // into the next digit exactly when the digit reaches 10.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < N; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
    shifted = {bcd_adj, bin_q} << 1;
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          bin_d   = i_bin;
          bcd_d   = '0;
          cnt_d   = CW'(W);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bin_d = shifted[W-1:0];
        bcd_d = shifted[4*N+W-1:W];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (i_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_ready     = (state_q == S_IDLE);
    o_valid     = (state_q == S_DONE);
    o_bcd       = bcd_q;
    o_dbg_state = state_q;
  end

`ifdef LIBSV_BCD_ENCODER_SERIAL_OVERFLOW_EN
  logic ovf_q, ovf_d;

  // A 1 leaving the top digit means the running value reached 10^N.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == S_IDLE && i_valid) begin
      ovf_d = 1'b0;
    end else if (state_q == S_SHIFT) begin
      ovf_d = ovf_q | bcd_adj[4*N-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign o_overflow = ovf_q;
`else
  assign o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_encoder_serial.sv
// Self-checking bench for bcd_encoder_serial (N=3, W=10) with an expected-result
// queue; overflow expectations follow LIBSV_BCD_ENCODER_SERIAL_OVERFLOW_EN.
module tb_bcd_encoder_serial;

  localparam int N = 3;
  localparam int W = 10;

  logic           clk;
  logic           i_rst;
  logic [W-1:0]   i_bin;
  logic           i_valid;
  logic           o_ready;
  logic [4*N-1:0] o_bcd;
  logic           o_overflow;
  logic           o_valid;
  logic           i_ready;
  logic [1:0]     o_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cyc = 0;

  logic [4*N:0] exp_q[$];

  bcd_encoder_serial #(.N(N)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_bin       (i_bin),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_bcd       (o_bcd),
    .o_overflow  (o_overflow),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_dbg_state (o_dbg_state)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4*N:0] model(input int v);
    int m;
    logic ovf;
    m = v % 1000;
`ifdef LIBSV_BCD_ENCODER_SERIAL_OVERFLOW_EN
    ovf = (v > 999);
`else
    ovf = 1'b0;
`endif
    return {ovf, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  // scoreboard: compare on every completed output handshake
  always @(negedge clk) begin
    if (!i_rst && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        chk("result", 32'({o_overflow, o_bcd}), 32'(exp_q.pop_front()));
      end
    end
  end

  // Drivers run at posedge+1; waits until an edge sees ready high with valid.
  task automatic wait_accept(output int c);
    logic rdy_before;
    c = -1;
    for (int i = 0; i < 60; i++) begin
      rdy_before = o_ready;
      @(posedge clk); #1;
      if (rdy_before && !o_ready) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) chk("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic accept(input int v, input bit push);
    i_bin   = W'(v);
    i_valid = 1'b1;
    if (push) exp_q.push_back(model(v));
    wait_accept(acc_cyc);
    i_valid = 1'b0;
    i_bin   = W'($urandom_range(0, 1023));
  endtask

  task automatic wait_valid(output int lat);
    lat = 999;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_valid) begin
        lat = cyc - acc_cyc;
        break;
      end
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int lat;
    int a1, a2, a3;
    bit saw;
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_bin   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_bcd", 32'(o_bcd), 32'd0);
    chk("rst_ovf", 32'(o_overflow), 32'd0);
    chk("rst_state", 32'(o_dbg_state), 32'd0);

    // first edge after reset must accept
    i_rst = 1'b0;
    a1 = cyc;
    accept(0, 1);
    chk("first_accept_edge", 32'(acc_cyc - a1), 32'd1);
    wait_valid(lat);
    chk("latency_0", 32'(lat), 32'd10);
    @(posedge clk); #1;
    wait_drain();

    accept(999, 1);
    wait_valid(lat);
    chk("latency_999", 32'(lat), 32'd10);
    @(posedge clk); #1;
    accept(1023, 1);
    wait_valid(lat);
    chk("latency_1023", 32'(lat), 32'd10);
    @(posedge clk); #1;
    wait_drain();

    // backpressure: result held while i_ready is low
    i_ready = 1'b0;
    accept(437, 1);
    wait_valid(lat);
    chk("latency_437", 32'(lat), 32'd10);
    for (int i = 0; i < 5; i++) begin
      chk("hold_bcd", 32'(o_bcd), 32'h437);
      chk("hold_ready", 32'(o_ready), 32'd0);
      chk("hold_valid", 32'(o_valid), 32'd1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    i_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_ready", 32'(o_ready), 32'd1);
    chk("release_state", 32'(o_dbg_state), 32'd0);
    wait_drain();

    // reset mid-conversion discards the result
    accept(512, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    chk("abort_ready", 32'(o_ready), 32'd1);
    chk("abort_bcd", 32'(o_bcd), 32'd0);
    chk("abort_state", 32'(o_dbg_state), 32'd0);
    saw = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (o_valid) saw = 1'b1;
    end
    chk("abort_no_valid", 32'(saw), 32'd0);
    @(posedge clk); #1;
    accept(58, 1);
    wait_valid(lat);
    chk("latency_58", 32'(lat), 32'd10);
    @(posedge clk); #1;
    wait_drain();

    // back-to-back stream with i_valid held high
    i_valid = 1'b1;
    i_bin = W'(1); exp_q.push_back(model(1));
    wait_accept(a1);
    i_bin = W'(2); exp_q.push_back(model(2));
    wait_accept(a2);
    i_bin = W'(3); exp_q.push_back(model(3));
    wait_accept(a3);
    i_valid = 1'b0;
    chk("stream_gap_12", 32'(a2 - a1), 32'd12);
    chk("stream_gap_23", 32'(a3 - a2), 32'd12);
    wait_drain();

    for (int v = 0; v < 1024; v++) begin
      accept(v, 1);
    end
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_encoder_serial.md
BCD_ENCODER_SERIAL -- requirements
Module: bcd_encoder_serial

Interface
REQ-001 SHALL have parameter N, default 3, the number of BCD digits produced; legal range N >= 1.
REQ-002 SHALL derive the local binary width W = 3*N+(N+2)/3, matching the binary width consumed and produced by the team's N-digit BCD decoder.
REQ-003 i_clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous and active-high.
REQ-005 i_bin  input  W  unsigned binary value to convert; sampled only on an accepting edge.
REQ-006 i_valid  input  1  upstream asserts that i_bin is valid.
REQ-007 o_ready  output  1  block can accept a new value.
REQ-008 o_bcd  output  4*N  packed BCD result; digit k occupies bits [4k+3:4k], with digit 0 least significant.
REQ-009 o_overflow  output  1  i_bin exceeded 10^N-1; qualified by o_valid.
REQ-010 o_valid  output  1  o_bcd and o_overflow are valid.
REQ-011 i_ready  input  1  downstream accepts the result.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, SHIFT and DONE.
REQ-013 IDLE: o_ready=1 and o_valid=0; an edge with i_valid=1 SHALL load i_bin into a W-bit shift register, clear the BCD register and overflow flag, load the step counter with W, and enter SHIFT.
REQ-014 SHIFT: each edge SHALL perform one double-dabble step.
- First, add 3 to every BCD digit that is >= 5.
- Then shift {BCD register, binary register} left by one bit.
- Then decrement the counter.
- o_ready=0 and o_valid=0 throughout SHIFT.
REQ-015 SHALL set the overflow flag whenever the bit shifted out of BCD digit N-1 is 1; the flag is sticky for the conversion.
REQ-016 SHALL enter DONE on the edge performing the W-th step; o_valid SHALL rise on exactly the W-th edge after the accepting edge.
REQ-017 DONE: o_valid=1; o_bcd and o_overflow SHALL hold stable until an edge with i_ready=1, which returns the FSM to IDLE.
REQ-018 SHALL not accept new input in DONE or SHIFT; minimum accept-to-accept period is W+2 cycles.
REQ-019 For i_bin <= 10^N-1, o_bcd SHALL equal the exact BCD of i_bin and o_overflow SHALL be 0.
REQ-020 For i_bin > 10^N-1, o_bcd SHALL equal the BCD of (i_bin mod 10^N) and o_overflow SHALL be 1.
REQ-021 i_ready SHALL be ignored outside DONE, and i_valid SHALL be ignored outside IDLE.
REQ-022 Changes on i_bin after the accepting edge SHALL not affect the result.

Reset
REQ-023 While i_rst=1 at an edge, the block SHALL enter IDLE with these values:
- o_ready=1, o_valid=0
- o_bcd=0, o_overflow=0
- counter=0, shift registers=0
REQ-024 Reset SHALL take priority over every handshake, and an assertion mid-SHIFT or in DONE SHALL abort the conversion and discard the result.
REQ-025 The first acceptance after reset SHALL be possible on the first edge with i_rst=0.

Configuration
REQ-026 With macro LIBSV_BCD_ENCODER_SERIAL_OVERFLOW_EN defined, overflow detection SHALL be implemented per REQ-015 and REQ-020.
REQ-027 Without that macro, the o_overflow port SHALL remain present but be tied to 0, and no detection logic SHALL be synthesised; o_bcd behaviour SHALL be unchanged.

Verification (N=3, W=10, macro defined unless stated)
REQ-028 Accept i_bin=0 with i_ready=1 -> o_valid on the 10th edge after acceptance, with o_bcd=12'h000 and o_overflow=0.
REQ-029 Accept i_bin=999 -> o_bcd=12'h999 and o_overflow=0; accept i_bin=1023 -> o_bcd=12'h023 and o_overflow=1; with the macro undefined, 1023 -> o_bcd=12'h023 and o_overflow=0.
REQ-030 Accept i_bin=437 with i_ready=0 for 5 cycles after o_valid -> o_bcd=12'h437 held stable and o_ready=0 throughout; i_ready=1 -> IDLE and o_ready=1 on the next cycle.
REQ-031 Assert i_rst for 1 cycle at step 4 of the conversion of 512 -> o_valid never asserts for 512; then accept 58 -> o_bcd=12'h058.
REQ-032 i_valid held high with values 1, 2, 3 and i_ready held high -> three results 12'h001, 12'h002 and 12'h003 in order, with acceptances exactly 12 cycles apart.
REQ-033 Exhaustive sweep of i_bin over 0..1023 -> o_bcd matches a reference conversion of (i_bin mod 1000) and o_overflow=(i_bin>999) for every value.
